// File: rtl/sobel_window_core.sv
// 3x3 Sobel window core: assembles a pixel window from the live stream and two
// line-buffer taps, then produces a saturated gradient magnitude and edge flag.
module sobel_window_core #(
  parameter int WIDTH  = 699,
  parameter int HEIGHT = 480,
  parameter int THRESH = 128
) (
  input  logic       sys_clk_i,
  input  logic       sys_rst_i,
  input  logic [7:0] pix_i,
  input  logic [7:0] line1_i,
  input  logic [7:0] line2_i,
  input  logic       pix_vld_i,
  input  logic       line_rdy_i,
  output logic [7:0] mag_o,
  output logic       edge_o,
  output logic       vld_o,
  output logic       frame_done_o
);

  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  logic [7:0]        w [0:2][0:2];
  logic [CW-1:0]     col_cnt;
  logic [RW-1:0]     row_cnt;
  logic              win_vld;
  logic              last0;
  logic              win_ok;
  logic              col_end;
  logic              row_end;

  logic signed [10:0] gx_c, gy_c;
  logic signed [10:0] gx, gy;
  logic               s1_vld;
  logic               s1_last;

  logic [10:0]        abs_x, abs_y, sum_c;
  logic [7:0]         mag_c;

  function automatic logic signed [10:0] ext(input logic [7:0] p);
    return {3'b000, p};
  endfunction

  // Windows starting at col 0/1 still hold the previous row's right edge.
  assign win_ok  = line_rdy_i && (col_cnt >= CW'(2));
  assign col_end = (col_cnt == CW'(WIDTH - 1));
  assign row_end = (row_cnt == RW'(HEIGHT - 1));

  // Stage 0: window shift and raster counters.
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      // NOTE: the window is only nine flops, so it is reset with the rest of
      // the pipeline; a reset mid-row must not leak old pixels into new output.
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          w[r][c] <= '0;
      col_cnt <= '0;
      row_cnt <= '0;
      win_vld <= 1'b0;
      last0   <= 1'b0;
    end else if (pix_vld_i) begin
      for (int r = 0; r < 3; r++) begin
        w[r][0] <= w[r][1];
        w[r][1] <= w[r][2];
      end
      w[0][2] <= line2_i;
      w[1][2] <= line1_i;
      w[2][2] <= pix_i;
      win_vld <= win_ok;
      last0   <= win_ok && col_end && row_end;
      if (col_end) begin
        col_cnt <= '0;
        row_cnt <= row_end ? '0 : row_cnt + RW'(1);
      end else begin
        col_cnt <= col_cnt + CW'(1);
      end
    end else begin
      win_vld <= 1'b0;
      last0   <= 1'b0;
    end
  end

  // NOTE: combinational blocks assign every output unconditionally so no
  // latch can be inferred.
  always_comb begin
    gx_c = (ext(w[0][2]) + (ext(w[1][2]) <<< 1) + ext(w[2][2]))
         - (ext(w[0][0]) + (ext(w[1][0]) <<< 1) + ext(w[2][0]));
    gy_c = (ext(w[2][0]) + (ext(w[2][1]) <<< 1) + ext(w[2][2]))
         - (ext(w[0][0]) + (ext(w[0][1]) <<< 1) + ext(w[0][2]));
  end

  // Stage 1: gradients.
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      gx      <= '0;
      gy      <= '0;
      s1_vld  <= 1'b0;
      s1_last <= 1'b0;
    end else begin
      gx      <= gx_c;
      gy      <= gy_c;
      s1_vld  <= win_vld;
      s1_last <= last0;
    end
  end

  always_comb begin
    abs_x = gx[10] ? 11'(-gx) : 11'(gx);
    abs_y = gy[10] ? 11'(-gy) : 11'(gy);
    sum_c = abs_x + abs_y;
    mag_c = (sum_c > 11'd255) ? 8'hFF : sum_c[7:0];
  end

  // Stage 2: magnitude and threshold; outputs hold across bubbles.
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      mag_o        <= '0;
      edge_o       <= 1'b0;
      vld_o        <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      vld_o        <= s1_vld;
      frame_done_o <= s1_vld && s1_last;
      if (s1_vld) begin
        mag_o  <= mag_c;
        edge_o <= (mag_c >= 8'(THRESH));
      end
    end
  end

endmodule

// File: tb/tb_sobel_window_core.sv
// Directed bench for sobel_window_core on an 8x4 frame: flat, step and ramp
// images, stream gaps, line_rdy gating, frame end and asynchronous reset.
module tb_sobel_window_core;

  localparam int W = 8;
  localparam int H = 4;

  localparam int P_FLAT  = 0;
  localparam int P_STEP  = 1;
  localparam int P_HRAMP = 2;
  localparam int P_VRAMP = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] pix = '0, line1 = '0, line2 = '0;
  logic       pix_vld = 1'b0;
  logic       line_rdy = 1'b0;
  logic [7:0] mag;
  logic       edge_flag;
  logic       vld;
  logic       frame_done;
  bit         clk_run = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int mag;
    int edg;
    int fd;
    int cyc;
  } out_t;
  out_t q[$];

  sobel_window_core #(.WIDTH(W), .HEIGHT(H), .THRESH(128)) dut (
    .sys_clk_i    (clk),
    .sys_rst_i    (rst_n),
    .pix_i        (pix),
    .line1_i      (line1),
    .line2_i      (line2),
    .pix_vld_i    (pix_vld),
    .line_rdy_i   (line_rdy),
    .mag_o        (mag),
    .edge_o       (edge_flag),
    .vld_o        (vld),
    .frame_done_o (frame_done)
  );

  initial forever begin
    #5;
    if (clk_run) clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (rst_n && vld) q.push_back('{int'(mag), int'(edge_flag), int'(frame_done), cyc});

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pixel for window row r_off (0 = line2/top, 2 = pix/bottom) at column col.
  function automatic int pv(input int pat, input int r_off, input int col);
    case (pat)
      P_FLAT:  return 100;
      P_STEP:  return (col < 4) ? 0 : 255;
      P_HRAMP: return col * 10;
      default: return r_off * 20;
    endcase
  endfunction

  // Hand-derived magnitude for window centre 1..6.
  function automatic int exp_mag(input int pat, input int centre);
    case (pat)
      P_FLAT:  return 0;
      P_STEP:  return (centre == 3 || centre == 4) ? 255 : 0;
      P_HRAMP: return 80;
      default: return 160;
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      pix_vld = 1'b0;
    end
  endtask

  task automatic feed_row(input int pat, input int ncols, input int gap_at,
                          input bit rdy, output int third_cyc);
    third_cyc = -1;
    for (int c = 0; c < ncols; c++) begin
      if (c == gap_at) idle(5);
      @(negedge clk);
      pix_vld  = 1'b1;
      line_rdy = rdy;
      line2    = 8'(pv(pat, 0, c));
      line1    = 8'(pv(pat, 1, c));
      pix      = 8'(pv(pat, 2, c));
      if (c == 2) third_cyc = cyc + 1;
    end
    idle(4);
  endtask

  task automatic check_row(input string tag, input int pat, input int n,
                           input bit fd_last, output int first_cyc);
    out_t e;
    first_cyc = (q.size() > 0) ? q[0].cyc : -1;
    check($sformatf("%s_count", tag), q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (q.size() == 0) break;
      e = q.pop_front();
      check($sformatf("%s_mag%0d", tag, i + 1), e.mag, exp_mag(pat, i + 1));
      check($sformatf("%s_edge%0d", tag, i + 1), e.edg,
            (exp_mag(pat, i + 1) >= 128) ? 1 : 0);
      check($sformatf("%s_fd%0d", tag, i + 1), e.fd, (fd_last && i == n - 1) ? 1 : 0);
    end
  endtask

  initial begin
    int third, first;

    // Reset with the clock stopped.
    #1 rst_n = 1'b0;
    #1;
    check("rst0_mag", int'(mag), 0);
    check("rst0_edge", int'(edge_flag), 0);
    check("rst0_vld", int'(vld), 0);
    check("rst0_fd", int'(frame_done), 0);
    #2 rst_n = 1'b1;
    clk_run = 1'b1;

    // Frame 1: flat, step, horizontal ramp, vertical ramp.
    feed_row(P_FLAT, W, -1, 1'b1, third);
    check_row("flat", P_FLAT, 6, 1'b0, first);
    check("flat_first_lat", first, third + 2);
    feed_row(P_STEP, W, -1, 1'b1, third);
    check_row("step", P_STEP, 6, 1'b0, first);
    feed_row(P_HRAMP, W, -1, 1'b1, third);
    check_row("hramp", P_HRAMP, 6, 1'b0, first);
    feed_row(P_VRAMP, W, -1, 1'b1, third);
    check_row("vramp_fend", P_VRAMP, 6, 1'b1, first);

    // Frame 2 row 0: step with a five-cycle gap before column 5.
    feed_row(P_STEP, W, 5, 1'b1, third);
    if (q.size() >= 6) begin
      check("gap_len", q[3].cyc - q[2].cyc, 6);
      check("gap_span", q[5].cyc - q[0].cyc, 10);
    end else begin
      check("gap_outputs", q.size(), 6);
    end
    check_row("gapstep", P_STEP, 6, 1'b0, first);
    check("gap_restart_lat", first, third + 2);

    // Row 1 with line_rdy low: no outputs at all.
    feed_row(P_FLAT, W, -1, 1'b0, third);
    check("nordy_count", q.size(), 0);
    q.delete();

    // Row 2: partial vertical ramp, then asynchronous reset mid-row.
    feed_row(P_VRAMP, 6, -1, 1'b1, third);
    check_row("partial", P_VRAMP, 4, 1'b0, first);
    check("pre_rst_mag", int'(mag), 160);
    check("pre_rst_edge", int'(edge_flag), 1);
    clk_run = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst1_mag", int'(mag), 0);
    check("rst1_edge", int'(edge_flag), 0);
    check("rst1_vld", int'(vld), 0);
    check("rst1_fd", int'(frame_done), 0);
    #5 rst_n = 1'b1;
    #3 clk_run = 1'b1;

    // Restarted frame: must begin at col 0, row 0.
    feed_row(P_HRAMP, W, -1, 1'b1, third);
    check_row("post_rst", P_HRAMP, 6, 1'b0, first);
    check("post_rst_lat", first, third + 2);
    feed_row(P_FLAT, W, -1, 1'b1, third);
    check_row("f3r1", P_FLAT, 6, 1'b0, first);
    feed_row(P_FLAT, W, -1, 1'b1, third);
    check_row("f3r2", P_FLAT, 6, 1'b0, first);
    feed_row(P_FLAT, W, -1, 1'b1, third);
    check_row("f3r3", P_FLAT, 6, 1'b1, first);
    check("tail_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got %0d cycles expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sobel_window_core.md
Name: sobel_window_core

Overview:
- Consumes the pixel stream plus the two delayed rows produced by the single-line FIFO buffers.
- Assembles a 3x3 pixel window and computes the Sobel Gx/Gy gradients.
- Outputs a saturated 8-bit gradient magnitude and a thresholded edge flag.
- Sits directly downstream of the line-buffer pair; feeds the edge-image writer.

Parameters:
- WIDTH, 699, pixels per row; equals line-buffer DEPTH.
- HEIGHT, 480, rows per frame.
- THRESH, 128, edge threshold on the saturated magnitude (0..255).

Ports:
- sys_clk_i  input  1  system clock, rising-edge.
- sys_rst_i  input  1  asynchronous, active-low reset.
- pix_i  input  8  current-row pixel (bottom window row).
- line1_i  input  8  pixel from one row earlier (middle row); first line buffer data_o.
- line2_i  input  8  pixel from two rows earlier (top row); second line buffer data_o.
- pix_vld_i  input  1  pix_i/line1_i/line2_i valid this cycle; same strobe as the buffers' write enable.
- line_rdy_i  input  1  both line buffers primed (AND of their done_o).
- mag_o  output  8  min(|Gx|+|Gy|, 255).
- edge_o  output  1  mag_o >= THRESH.
- vld_o  output  1  mag_o/edge_o valid this cycle.
- frame_done_o  output  1  one-cycle pulse with the last valid output of a frame.

Behaviour:
- Reset: asserting sys_rst_i low immediately clears, without a clock edge:
  - all window and pipeline registers;
  - col_cnt and row_cnt;
  - mag_o=0, edge_o=0, vld_o=0, frame_done_o=0.
- Reset mid-row: on release, the block restarts at col 0, row 0. No residual outputs.
- Window registers w[r][c], r=0 top, r=2 bottom, c=0 left, c=2 right.
- Stage 0 (edge where pix_vld_i=1):
  - Each row shifts left: w[r][0]<=w[r][1], w[r][1]<=w[r][2].
  - New pixels load into the right column: w[0][2]<=line2_i, w[1][2]<=line1_i, w[2][2]<=pix_i.
  - win_vld<=line_rdy_i && (col_cnt>=2), using the pre-increment col_cnt.
  - last0<=win_vld-condition && col_cnt==WIDTH-1 && row_cnt==HEIGHT-1.
  - col_cnt wraps WIDTH-1 -> 0. row_cnt increments on that wrap and wraps HEIGHT-1 -> 0.
- Stage 0 (edge where pix_vld_i=0): window and counters hold; win_vld<=0.
- Stage 1:
  - Gx=(w02+2*w12+w22)-(w00+2*w10+w20).
  - Gy=(w20+2*w21+w22)-(w00+2*w01+w02).
  - Both are 11-bit signed, range -1020..+1020, no overflow.
  - win_vld and last propagate alongside.
- Stage 2:
  - sum=|Gx|+|Gy|, 11-bit unsigned, max 2040.
  - mag_o=sum>255 ? 255 : sum[7:0]; edge_o=(mag_o-equivalent >= THRESH).
  - vld_o<=stage-1 valid; frame_done_o<=stage-1 last && valid.
- Latency: pixel sampled on edge k produces vld_o/mag_o on edge k+2.
- The pipeline is free-running with no backpressure. Gaps in pix_vld_i insert vld_o=0 bubbles but do not corrupt the window.
- Output count per row: WIDTH-2, centred on columns 1..WIDTH-2. Row-start windows containing previous-row pixels are suppressed by the col_cnt>=2 gate.
- While line_rdy_i=0, counters still advance but vld_o stays 0.
- When vld_o=0, mag_o and edge_o hold their last values.

Test Plan:
- Reset: drive sys_rst_i low with the clock stopped -> mag_o=0, edge_o=0, vld_o=0, frame_done_o=0 immediately. Release -> no vld_o until line_rdy_i=1 and col_cnt>=2.
- Flat image (WIDTH=8, HEIGHT=4, all pixels 100, line_rdy_i=1) -> 6 vld_o pulses per row, each mag_o=0, edge_o=0. First vld_o is 2 edges after the third accepted pixel.
- Vertical step (cols 0-3 = 0, cols 4-7 = 255, all rows):
  - window centres 1..6 -> mag_o = 0,0,255,255,0,0;
  - edge_o = 0,0,1,1,0,0 (centres 3 and 4 have Gx=1020, saturated).
- Horizontal ramp (pixel=col*10, all rows) -> every output mag_o=80 (Gx=80, Gy=0), edge_o=0 with THRESH=128.
- Vertical ramp (row r pixel = r*20; line2/line1/pix = 0/20/40) -> Gy=160, mag_o=160, edge_o=1.
- Stream gaps:
  - repeat the step image with pix_vld_i low for 5 cycles mid-row -> identical mag_o sequence, vld_o low for exactly 5 cycles;
  - line_rdy_i=0 for a full row -> zero vld_o pulses for that row.
- Frame end (WIDTH=8, HEIGHT=4, line_rdy_i=1 throughout):
  - frame_done_o pulses exactly once, coincident with the 6th vld_o of row 3;
  - the next frame restarts at col 0, row 0.
- Async reset asserted mid-row 2 -> outputs clear immediately. After release, the first vld_o follows 3 new accepted pixels.
